scr1_tapc_dr_scan: RTL and testbench

- Data-register scan stage directly downstream of the TAP controller state machine.
- Consumes the TAP state (4-bit TAP state encoding, RESET=0 … IR_UPDATE=15) and the current 4-bit TAP instruction code.
- Runs capture/shift/update of the selected data register in the system clock domain, qualified by a one-cycle TCK-rise strobe.
- Produces TDO and the update-side register outputs: DAP command, SYS_CTRL, MTAP_SWITCH.

---
 rtl/scr1_tapc_dr_scan_if.sv | 26 ++
 rtl/scr1_tapc_dr_scan.sv | 129 ++++++++++++
 tb/tb_scr1_tapc_dr_scan.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/scr1_tapc_dr_scan_if.sv
// TAP-side bundle for the DR scan stage: TAP state/instruction/strobe in, TDO and update-side registers out.
interface scr1_tapc_dr_scan_if #(
  parameter int DAP_CMD_WIDTH = 36
);
  logic                     tck_stb_i;
  logic [3:0]               tap_state_i;
  logic [3:0]               tap_instr_i;
  logic                     tdi_i;
  logic                     tdo_o;
  logic                     tdo_en_o;
  logic [DAP_CMD_WIDTH-1:0] dap_cmd_rdata_i;
  logic [DAP_CMD_WIDTH-1:0] dap_cmd_wdata_o;
  logic                     dap_cmd_upd_o;
  logic                     sys_ctrl_o;
  logic                     mtap_switch_o;

  modport master (
    output tck_stb_i, tap_state_i, tap_instr_i, tdi_i, dap_cmd_rdata_i,
    input  tdo_o, tdo_en_o, dap_cmd_wdata_o, dap_cmd_upd_o, sys_ctrl_o, mtap_switch_o
  );

  modport slave (
    input  tck_stb_i, tap_state_i, tap_instr_i, tdi_i, dap_cmd_rdata_i,
    output tdo_o, tdo_en_o, dap_cmd_wdata_o, dap_cmd_upd_o, sys_ctrl_o, mtap_switch_o
  );
endinterface

// File: rtl/scr1_tapc_dr_scan.sv
// TAP data-register capture/shift/update in the clk domain, one action per TCK-rise strobe.
// Optional BLD_ID register enabled by `SCR1_TAPC_BLD_ID_EN (otherwise 4'h4 behaves as BYPASS).
`ifndef SCR1_MIMPID
`define SCR1_MIMPID 32'h22011200
`endif

module scr1_tapc_dr_scan #(
  parameter int          DAP_CMD_WIDTH = 36,
  parameter logic [31:0] IDCODE_VALUE  = 32'hDEB01001,
  parameter logic [31:0] BLD_ID_VALUE  = `SCR1_MIMPID
) (
  input logic                clk,
  input logic                rst,
  scr1_tapc_dr_scan_if.slave bus
);
  localparam int SR_W = (DAP_CMD_WIDTH > 32) ? DAP_CMD_WIDTH : 32;

  localparam logic [3:0] TAP_RESET      = 4'd0;
  localparam logic [3:0] TAP_DR_CAPTURE = 4'd3;
  localparam logic [3:0] TAP_DR_SHIFT   = 4'd4;
  localparam logic [3:0] TAP_DR_UPDATE  = 4'd8;
  localparam logic [3:0] TAP_IR_SEL     = 4'd9;

  localparam logic [3:0] INSTR_BLD_ID   = 4'h4;
  localparam logic [3:0] INSTR_DAP_CMD  = 4'h8;
  localparam logic [3:0] INSTR_SYS_CTRL = 4'h9;
  localparam logic [3:0] INSTR_MTAP_SW  = 4'hD;
  localparam logic [3:0] INSTR_IDCODE   = 4'hE;
  localparam logic [3:0] INSTR_BYPASS   = 4'hF;

  localparam logic [0:0] SCAN_IDLE   = 1'b0;
  localparam logic [0:0] SCAN_ACTIVE = 1'b1;

  logic [0:0]               scan_state;
  logic [3:0]               instr_q;
  logic [SR_W-1:0]          sr;
  logic [SR_W-1:0]          sr_cap;
  logic [SR_W-1:0]          sr_shift;
  logic                     tdo_q;
  logic                     tdo_en_q;
  logic [DAP_CMD_WIDTH-1:0] wdata_q;
  logic                     upd_q;
  logic                     sys_ctrl_q;
  logic                     mtap_q;

`ifndef SCR1_TAPC_BLD_ID_EN
  logic unused_bld_id;
  assign unused_bld_id = ^BLD_ID_VALUE;
`endif

  // Capture decodes the incoming instruction; it is latched at the same edge.
  always_comb begin
    sr_cap = '0;
    case (bus.tap_instr_i)
      INSTR_IDCODE:   sr_cap[31:0] = IDCODE_VALUE;
`ifdef SCR1_TAPC_BLD_ID_EN
      INSTR_BLD_ID:   sr_cap[31:0] = BLD_ID_VALUE;
`endif
      INSTR_DAP_CMD:  sr_cap[DAP_CMD_WIDTH-1:0] = bus.dap_cmd_rdata_i;
      INSTR_SYS_CTRL: sr_cap[0] = sys_ctrl_q;
      INSTR_MTAP_SW:  sr_cap[0] = mtap_q;
      default:        sr_cap = '0;
    endcase
  end

  // TDI enters at the top of the active length so bits above it stay zero.
  always_comb begin
    sr_shift = sr >> 1;
    case (instr_q)
      INSTR_IDCODE:  sr_shift[31] = bus.tdi_i;
`ifdef SCR1_TAPC_BLD_ID_EN
      INSTR_BLD_ID:  sr_shift[31] = bus.tdi_i;
`endif
      INSTR_DAP_CMD: sr_shift[DAP_CMD_WIDTH-1] = bus.tdi_i;
      default:       sr_shift[0] = bus.tdi_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_state <= SCAN_IDLE;
      instr_q    <= INSTR_BYPASS;
      sr         <= '0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
      wdata_q    <= '0;
      upd_q      <= 1'b0;
      sys_ctrl_q <= 1'b0;
      mtap_q     <= 1'b0;
    end else begin
      upd_q    <= 1'b0;
      tdo_q    <= (bus.tap_state_i == TAP_DR_SHIFT) & sr[0];
      tdo_en_q <= (bus.tap_state_i == TAP_DR_SHIFT);
      if (bus.tap_state_i == TAP_RESET) begin
        sys_ctrl_q <= 1'b0;
        mtap_q     <= 1'b0;
        scan_state <= SCAN_IDLE;
      end else if (bus.tck_stb_i) begin
        if (bus.tap_state_i == TAP_DR_CAPTURE) begin
          instr_q    <= bus.tap_instr_i;
          sr         <= sr_cap;
          scan_state <= SCAN_ACTIVE;
        end else if (bus.tap_state_i == TAP_DR_SHIFT && scan_state == SCAN_ACTIVE) begin
          sr <= sr_shift;
        end else if (bus.tap_state_i == TAP_DR_UPDATE && scan_state == SCAN_ACTIVE) begin
          case (instr_q)
            INSTR_DAP_CMD: begin
              wdata_q <= sr[DAP_CMD_WIDTH-1:0];
              upd_q   <= 1'b1;
            end
            INSTR_SYS_CTRL: sys_ctrl_q <= sr[0];
            INSTR_MTAP_SW:  mtap_q     <= sr[0];
            default: ;
          endcase
          scan_state <= SCAN_IDLE;
        end else if (bus.tap_state_i >= TAP_IR_SEL) begin
          scan_state <= SCAN_IDLE;
        end
      end
    end
  end

  assign bus.tdo_o           = tdo_q;
  assign bus.tdo_en_o        = tdo_en_q;
  assign bus.dap_cmd_wdata_o = wdata_q;
  assign bus.dap_cmd_upd_o   = upd_q;
  assign bus.sys_ctrl_o      = sys_ctrl_q;
  assign bus.mtap_switch_o   = mtap_q;
endmodule

// File: tb/tb_scr1_tapc_dr_scan.sv
// Bench for scr1_tapc_dr_scan: per-clk vector table plus TCK-level scans checked through a TDO scoreboard.
module tb_scr1_tapc_dr_scan;
  localparam int W = 36;
  localparam logic [3:0] S_RESET = 4'd0, S_IDLE = 4'd1, S_CAP = 4'd3, S_SHIFT = 4'd4,
                         S_EXIT1 = 4'd5, S_PAUSE = 4'd6, S_UPD = 4'd8, S_IRCAP = 4'd10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scr1_tapc_dr_scan_if #(.DAP_CMD_WIDTH(W)) bus ();
  scr1_tapc_dr_scan #(.DAP_CMD_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0] st;
    logic [3:0] ins;
    logic       stb;
    logic       tdi;
    logic       tdo;
    logic       en;
    logic       sys;
    logic       mtap;
  } vec_t;

  vec_t tbl [21];
  int   n_cmp = 0;
  int   n_err = 0;
  logic s_tdo, s_en, s_upd_a, s_upd_b;
  logic exp_q [$];

  function automatic vec_t v(input logic [3:0] st, input logic [3:0] ins, input logic stb,
                             input logic tdi, input logic tdo, input logic en,
                             input logic sys, input logic mtap);
    vec_t r;
    r.st = st; r.ins = ins; r.stb = stb; r.tdi = tdi;
    r.tdo = tdo; r.en = en; r.sys = sys; r.mtap = mtap;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One TCK rise: a strobe clk then a quiet clk in the same TAP state.
  task automatic tck(input logic [3:0] st, input logic [3:0] ins, input logic tdi);
    @(negedge clk);
    bus.tap_state_i = st; bus.tap_instr_i = ins; bus.tdi_i = tdi; bus.tck_stb_i = 1'b1;
    @(posedge clk); #1;
    s_tdo = bus.tdo_o; s_en = bus.tdo_en_o; s_upd_a = bus.dap_cmd_upd_o;
    @(negedge clk);
    bus.tck_stb_i = 1'b0;
    @(posedge clk); #1;
    s_upd_b = bus.dap_cmd_upd_o;
  endtask

  task automatic push_bits(input logic [63:0] val, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(val[i]);
  endtask

  task automatic scan_shift(input logic [3:0] ins, input logic tdi, input string name);
    logic e;
    tck(S_SHIFT, ins, tdi);
    check({name, " tdo_en"}, 64'(s_en), 64'(1'b1));
    if (exp_q.size() == 0) begin
      check({name, " scoreboard underflow"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check({name, " tdo"}, 64'(s_tdo), 64'(e));
    end
  endtask

  initial begin
    logic [W-1:0] din;
    logic [3:0]   bp_tdi;

    tbl[0]  = v(S_UPD,   4'h8, 1, 0, 0, 0, 0, 0);
    tbl[1]  = v(S_UPD,   4'h8, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(S_CAP,   4'h9, 1, 0, 0, 0, 0, 0);
    tbl[3]  = v(S_SHIFT, 4'h9, 0, 1, 0, 1, 0, 0);
    tbl[4]  = v(S_SHIFT, 4'h9, 1, 1, 0, 1, 0, 0);
    tbl[5]  = v(S_SHIFT, 4'h9, 0, 0, 1, 1, 0, 0);
    tbl[6]  = v(S_EXIT1, 4'h9, 1, 0, 0, 0, 0, 0);
    tbl[7]  = v(S_UPD,   4'h9, 1, 0, 0, 0, 1, 0);
    tbl[8]  = v(S_IDLE,  4'h9, 1, 0, 0, 0, 1, 0);
    tbl[9]  = v(S_RESET, 4'h9, 0, 0, 0, 0, 0, 0);
    tbl[10] = v(S_CAP,   4'hD, 1, 0, 0, 0, 0, 0);
    tbl[11] = v(S_SHIFT, 4'hD, 1, 1, 0, 1, 0, 0);
    tbl[12] = v(S_PAUSE, 4'hD, 1, 0, 0, 0, 0, 0);
    tbl[13] = v(S_SHIFT, 4'hD, 0, 0, 1, 1, 0, 0);
    tbl[14] = v(S_UPD,   4'hD, 1, 0, 0, 0, 0, 1);
    tbl[15] = v(S_CAP,   4'hD, 1, 0, 0, 0, 0, 1);
    tbl[16] = v(S_SHIFT, 4'hD, 1, 0, 1, 1, 0, 1);
    tbl[17] = v(S_IRCAP, 4'hD, 1, 0, 0, 0, 0, 1);
    tbl[18] = v(S_UPD,   4'hD, 1, 0, 0, 0, 0, 1);
    tbl[19] = v(S_RESET, 4'hD, 0, 0, 0, 0, 0, 0);
    tbl[20] = v(S_UPD,   4'hD, 1, 0, 0, 0, 0, 0);

    rst = 1'b1;
    bus.tck_stb_i = 1'b0; bus.tap_state_i = S_IDLE; bus.tap_instr_i = 4'hF;
    bus.tdi_i = 1'b0; bus.dap_cmd_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset tdo", 64'(bus.tdo_o), 64'(0));
    check("reset tdo_en", 64'(bus.tdo_en_o), 64'(0));
    check("reset wdata", 64'(bus.dap_cmd_wdata_o), 64'(0));
    check("reset upd", 64'(bus.dap_cmd_upd_o), 64'(0));
    check("reset sys_ctrl", 64'(bus.sys_ctrl_o), 64'(0));
    check("reset mtap", 64'(bus.mtap_switch_o), 64'(0));
    check("reset instr_q", 64'(dut.instr_q), 64'(4'hF));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus.tap_state_i = tbl[i].st; bus.tap_instr_i = tbl[i].ins;
      bus.tck_stb_i = tbl[i].stb; bus.tdi_i = tbl[i].tdi;
      @(posedge clk); #1;
      check($sformatf("row%0d tdo", i), 64'(bus.tdo_o), 64'(tbl[i].tdo));
      check($sformatf("row%0d tdo_en", i), 64'(bus.tdo_en_o), 64'(tbl[i].en));
      check($sformatf("row%0d sys_ctrl", i), 64'(bus.sys_ctrl_o), 64'(tbl[i].sys));
      check($sformatf("row%0d mtap", i), 64'(bus.mtap_switch_o), 64'(tbl[i].mtap));
      check($sformatf("row%0d upd", i), 64'(bus.dap_cmd_upd_o), 64'(0));
    end
    @(negedge clk);
    bus.tck_stb_i = 1'b0;

    // IDCODE read-out
    tck(S_CAP, 4'hE, 0);
    check("idcode capture tdo_en", 64'(s_en), 64'(0));
    push_bits(64'(32'hDEB01001), 32);
    for (int i = 0; i < 32; i++) scan_shift(4'hE, 1'b0, $sformatf("idcode bit%0d", i));
    tck(S_EXIT1, 4'hE, 0);
    check("idcode exit tdo_en", 64'(s_en), 64'(0));
    tck(S_UPD, 4'hE, 0);
    check("idcode update no pulse", 64'(s_upd_a), 64'(0));

    // DAP_CMD read and write
    bus.dap_cmd_rdata_i = 36'h5_1234_5678;
    din = 36'hA_8765_4321;
    tck(S_CAP, 4'h8, 0);
    push_bits(64'(36'h5_1234_5678), W);
    for (int i = 0; i < W; i++) scan_shift(4'h8, din[i], $sformatf("dap bit%0d", i));
    tck(S_EXIT1, 4'h8, 0);
    check("dap wdata before update", 64'(bus.dap_cmd_wdata_o), 64'(0));
    tck(S_UPD, 4'h8, 0);
    check("dap upd pulse", 64'(s_upd_a), 64'(1));
    check("dap upd one clk", 64'(s_upd_b), 64'(0));
    check("dap wdata", 64'(bus.dap_cmd_wdata_o), 64'(din));
    tck(S_IDLE, 4'h8, 0);
    check("dap wdata hold", 64'(bus.dap_cmd_wdata_o), 64'(din));

    // BYPASS one-bit delay; instruction change mid-scan must not retarget the update
    bp_tdi = 4'b1101;
    tck(S_CAP, 4'hF, 0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++)
      scan_shift((i < 2) ? 4'hF : 4'h9, bp_tdi[i], $sformatf("bypass bit%0d", i));
    tck(S_UPD, 4'h9, 0);
    check("bypass ir change sys_ctrl", 64'(bus.sys_ctrl_o), 64'(0));

`ifndef SCR1_TAPC_BLD_ID_EN
    tck(S_CAP, 4'h4, 0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    scan_shift(4'h4, 1'b1, "bld_id off bit0");
    scan_shift(4'h4, 1'b0, "bld_id off bit1");
    tck(S_UPD, 4'h4, 0);
`endif

    // Reset in the middle of a DAP scan discards the pending update
    tck(S_CAP, 4'h8, 0);
    for (int i = 0; i < 3; i++) tck(S_SHIFT, 4'h8, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midscan rst wdata", 64'(bus.dap_cmd_wdata_o), 64'(0));
    check("midscan rst tdo_en", 64'(bus.tdo_en_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tck(S_UPD, 4'h8, 0);
    check("midscan rst upd strobe clk", 64'(s_upd_a), 64'(0));
    check("midscan rst upd next clk", 64'(s_upd_b), 64'(0));
    check("midscan rst wdata after upd", 64'(bus.dap_cmd_wdata_o), 64'(0));

    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
